ufm_i2c_ctrl: RTL and testbench

- Byte-level I2C slave sequencer for the UFM emulation path.
- Detects START/STOP and matches the 7-bit slave address.
- Sequences write/read bytes and owns the single open-drain SDA drive, sharing it between ACK generation and read-data transmit.
- The CPU side sees received bytes as one-cycle strobes and supplies read bytes on request; UDB clock `clk` is many times faster than SCL.

---
 rtl/ufm_i2c_ctrl_if.sv | 21 ++
 rtl/ufm_i2c_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ufm_i2c_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ufm_i2c_ctrl_if.sv
// Bus and CPU-side signals of the UFM I2C slave sequencer.
interface ufm_i2c_ctrl_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       stop_det;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_out, rx_data, rx_valid, tx_req, busy, stop_det
  );
  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_out, rx_data, rx_valid, tx_req, busy, stop_det
  );
endinterface

// File: rtl/ufm_i2c_ctrl.sv
// Byte-level I2C slave: START/STOP detect, address match, write/read byte
// sequencing, single registered open-drain SDA drive shared by ACK and read data.
module ufm_i2c_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic          clk,
  input  logic          rst_n,
  ufm_i2c_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx, rx_nx;
  logic       rw, rw_nx, mack, mack_nx, armed, armed_nx;
  logic       sda_nx, busy_nx, rxv_nx, txr_nx, stop_nx;
  logic       scl_d, sda_d;
  logic       rise, fall, start, stop;

  assign rise  = ~scl_d & bus.scl_in;
  assign fall  = scl_d & ~bus.scl_in;
  assign start = scl_d & bus.scl_in & sda_d & ~bus.sda_in;
  assign stop  = scl_d & bus.scl_in & ~sda_d & bus.sda_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd7;
      shreg        <= '0;
      rw           <= 1'b0;
      mack         <= 1'b0;
      armed        <= 1'b0;
      scl_d        <= 1'b1;
      sda_d        <= 1'b1;
      bus.sda_out  <= 1'b1;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.stop_det <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_cnt      <= bit_cnt_nx;
      shreg        <= shreg_nx;
      rw           <= rw_nx;
      mack         <= mack_nx;
      armed        <= armed_nx;
      scl_d        <= bus.scl_in;
      sda_d        <= bus.sda_in;
      bus.sda_out  <= sda_nx;
      bus.rx_data  <= rx_nx;
      bus.rx_valid <= rxv_nx;
      bus.tx_req   <= txr_nx;
      bus.busy     <= busy_nx;
      bus.stop_det <= stop_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    rw_nx      = rw;
    mack_nx    = mack;
    armed_nx   = armed;
    sda_nx     = bus.sda_out;
    busy_nx    = bus.busy;
    rx_nx      = bus.rx_data;
    rxv_nx     = 1'b0;
    txr_nx     = 1'b0;
    stop_nx    = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      sda_nx   = 1'b1;
      busy_nx  = 1'b0;
      stop_nx  = bus.busy;
    end else if (start) begin
      state_nx   = ADDR;
      bit_cnt_nx = 3'd7;
      sda_nx     = 1'b1;
      armed_nx   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        // The SCL fall that completes START is not a bit boundary; count
        // falls only once the first address bit has been clocked in.
        ADDR: begin
          if (rise) begin
            shreg_nx = {shreg[6:0], bus.sda_in};
            armed_nx = 1'b1;
          end else if (fall && armed) begin
            if (bit_cnt != 3'd0) begin
              bit_cnt_nx = bit_cnt - 3'd1;
            end else if (shreg[7:1] == SLAVE_ADDR) begin
              rw_nx      = shreg[0];
              sda_nx     = 1'b0;
              busy_nx    = 1'b1;
              bit_cnt_nx = 3'd7;
              state_nx   = ADDR_ACK;
            end else begin
              sda_nx   = 1'b1;
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            bit_cnt_nx = 3'd7;
            if (rw) begin
              txr_nx   = 1'b1;
              shreg_nx = bus.tx_data;
              sda_nx   = bus.tx_data[7];
              state_nx = RD_DATA;
            end else begin
              sda_nx   = 1'b1;
              state_nx = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (rise) begin
            shreg_nx = {shreg[6:0], bus.sda_in};
          end else if (fall) begin
            if (bit_cnt != 3'd0) begin
              bit_cnt_nx = bit_cnt - 3'd1;
            end else begin
              rx_nx    = shreg;
              rxv_nx   = 1'b1;
              sda_nx   = 1'b0;
              state_nx = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (fall) begin
            sda_nx     = 1'b1;
            bit_cnt_nx = 3'd7;
            state_nx   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (fall) begin
            if (bit_cnt != 3'd0) begin
              shreg_nx   = {shreg[6:0], 1'b0};
              sda_nx     = shreg[6];
              bit_cnt_nx = bit_cnt - 3'd1;
            end else begin
              sda_nx   = 1'b1;
              state_nx = RD_ACK;
            end
          end
        end
        RD_ACK: begin
          if (rise) begin
            mack_nx = ~bus.sda_in;
          end else if (fall) begin
            if (mack) begin
              txr_nx     = 1'b1;
              shreg_nx   = bus.tx_data;
              sda_nx     = bus.tx_data[7];
              bit_cnt_nx = 3'd7;
              state_nx   = RD_DATA;
            end else begin
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ufm_i2c_ctrl.sv
// Bit-banged I2C master driving ufm_i2c_ctrl with random transactions,
// checked against expectations derived from the transaction description.
module tb_ufm_i2c_ctrl;
  localparam int Q = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   stop_cnt = 0;
  logic low_seen = 1'b0;
  logic rxv_p = 1'b0, txr_p = 1'b0, stp_p = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  ufm_i2c_ctrl_if ifc();
  assign ifc.scl_in = scl;
  assign ifc.sda_in = sda_m & ifc.sda_out;

  ufm_i2c_ctrl #(.SLAVE_ADDR(7'h50)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.rx_valid) begin
      rx_q.push_back(ifc.rx_data);
      chk("rx_valid_width", 32'(rxv_p), 0);
    end
    if (ifc.tx_req) begin
      tx_q.push_back(ifc.tx_data);
      chk("tx_req_width", 32'(txr_p), 0);
    end
    if (ifc.stop_det) begin
      stop_cnt++;
      chk("stop_det_width", 32'(stp_p), 0);
    end
    if (ifc.sda_out === 1'b0) low_seen = 1'b1;
    rxv_p <= ifc.rx_valid;
    txr_p <= ifc.tx_req;
    stp_p <= ifc.stop_det;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl = 1'b1; tick(Q);
    s = ifc.sda_in; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(~ack, s);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    tx_q.delete();
    stop_cnt = 0;
    low_seen = 1'b0;
  endtask

  // kind 0: write to our address, 1: read from our address, 2: write elsewhere
  task automatic xact(input int kind, input int n);
    logic [6:0] addr;
    logic [7:0] d[$];
    logic [7:0] got;
    logic       ack, match, rd;
    rd = (kind == 1);
    addr = 7'h50;
    if (kind == 2) begin
      do addr = 7'($urandom); while (addr == 7'h50);
    end
    match = (addr == 7'h50);
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    clear_obs();
    if (rd) ifc.tx_data = d[0];
    i2c_start();
    wr_byte({addr, rd}, ack);
    chk("addr_ack", 32'(ack), 32'(match));
    if (rd) begin
      for (int i = 0; i < n; i++) begin
        ifc.tx_data = (i + 1 < n) ? d[i+1] : 8'hFF;
        rd_byte(i != n - 1, got);
        chk("rd_byte", 32'(got), 32'(d[i]));
      end
      chk("nack_busy", 32'(ifc.busy), 0);
      chk("nack_sda_rel", 32'(ifc.sda_out), 1);
    end else begin
      for (int i = 0; i < n; i++) begin
        wr_byte(d[i], ack);
        chk("wr_ack", 32'(ack), 32'(match));
      end
      chk("busy_pre_stop", 32'(ifc.busy), 32'(match));
    end
    i2c_stop(); tick(Q);
    chk("rx_count", 32'(rx_q.size()), (match && !rd) ? 32'(n) : 0);
    for (int i = 0; i < rx_q.size() && i < n; i++)
      chk("rx_data", 32'(rx_q[i]), 32'(d[i]));
    if (match && !rd) chk("rx_data_held", 32'(ifc.rx_data), 32'(d[n-1]));
    chk("tx_req_count", 32'(tx_q.size()), (match && rd) ? 32'(n) : 0);
    chk("stop_det_count", 32'(stop_cnt), 32'(match && !rd));
    chk("busy_after", 32'(ifc.busy), 0);
    if (!match) chk("no_sda_drive", 32'(low_seen), 0);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] b, r, got;
    ifc.tx_data = 8'h00;
    tick(3);
    chk("rst_sda_out", 32'(ifc.sda_out), 1);
    chk("rst_rx_data", 32'(ifc.rx_data), 0);
    chk("rst_rx_valid", 32'(ifc.rx_valid), 0);
    chk("rst_tx_req", 32'(ifc.tx_req), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_stop_det", 32'(ifc.stop_det), 0);
    rst_n = 1'b1;
    tick(4);

    xact(0, 2);
    xact(2, 1);
    xact(1, 2);
    for (int t = 0; t < 12; t++) xact(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));

    // STOP in the middle of a write data byte
    clear_obs();
    i2c_start();
    wr_byte(8'hA0, ack);
    chk("part_addr_ack", 32'(ack), 1);
    for (int i = 0; i < 4; i++) bit_x(1'($urandom_range(0, 1)), s);
    i2c_stop(); tick(Q);
    chk("part_rx_count", 32'(rx_q.size()), 0);
    chk("part_stop_det", 32'(stop_cnt), 1);
    chk("part_sda_out", 32'(ifc.sda_out), 1);
    chk("part_busy", 32'(ifc.busy), 0);

    // write then repeated START into a one-byte read
    b = 8'($urandom);
    r = 8'($urandom);
    clear_obs();
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(b, ack);
    chk("rs_wr_ack", 32'(ack), 1);
    ifc.tx_data = r;
    i2c_start();
    wr_byte(8'hA1, ack);
    chk("rs_rd_addr_ack", 32'(ack), 1);
    chk("rs_busy", 32'(ifc.busy), 1);
    rd_byte(1'b0, got);
    chk("rs_rd_byte", 32'(got), 32'(r));
    chk("rs_rx_data", 32'(ifc.rx_data), 32'(b));
    chk("rs_tx_req_count", 32'(tx_q.size()), 1);
    chk("rs_no_stop_yet", 32'(stop_cnt), 0);
    i2c_stop(); tick(Q);
    chk("rs_stop_det", 32'(stop_cnt), 0);
    chk("rs_rx_count", 32'(rx_q.size()), 1);

    // async reset while the address ACK is being driven
    clear_obs();
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_x(b[i] | 1'b1 ? 1'(8'hA0 >> i) : 1'b0, s);
    chk("ack_driven", 32'(ifc.sda_out), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_sda_rel", 32'(ifc.sda_out), 1);
    chk("async_busy", 32'(ifc.busy), 0);
    tick(2);
    rst_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 18; i++) bit_x(1'($urandom_range(0, 1)), s);
    chk("post_rst_sda", 32'(low_seen), 0);
    chk("post_rst_rx", 32'(rx_q.size()), 0);
    chk("post_rst_busy", 32'(ifc.busy), 0);
    i2c_stop(); tick(Q);
    chk("post_rst_stop_det", 32'(stop_cnt), 0);

    xact(0, 2);
    xact(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
